// File: rtl/ica_wupdate_ctrl.sv
// Iterative W-matrix update controller: W[e] += ((I_VAL - h[e] - p[e]) * W[e])[62:47]
// over nine elements per iteration, sharing one subtract-multiply-add datapath.
module ica_wupdate_ctrl #(
  parameter logic signed [63:0] I_VAL = 64'sd2305843009000000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         num_iter,
  input  logic               abort,
  output logic [3:0]         elem_idx,
  input  logic signed [63:0] h_data,
  input  logic signed [63:0] p_data,
  input  logic               w_ld,
  input  logic [3:0]         w_ld_idx,
  input  logic signed [15:0] w_ld_data,
  input  logic [3:0]         w_rd_idx,
  output logic signed [15:0] w_rd_data,
  output logic               busy,
  output logic               done,
  output logic [7:0]         iter_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] CALC  = 3'd2;
  localparam logic [2:0] UPD   = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]         state;
  logic [3:0]         idx;
  logic [7:0]         iter_tgt;
  logic               zero_wait;
  logic signed [63:0] diff;
  logic signed [79:0] prod;
  logic signed [15:0] w [9];
  logic signed [15:0] w_sel;
  logic signed [15:0] upd_val;
  logic               last_iter;
  logic               unused_prod;

  assign elem_idx    = idx;
  assign busy        = (state == FETCH) || (state == CALC) || (state == UPD);
  assign upd_val     = w_sel + prod[62:47];
  assign last_iter   = ({1'b0, iter_cnt} + 9'd1) >= {1'b0, iter_tgt};
  assign unused_prod = ^{prod[79:63], prod[46:0]};

  always_comb begin
    w_sel     = '0;
    w_rd_data = '0;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i))      w_sel     = w[i];
      if (w_rd_idx == 4'(i)) w_rd_data = w[i];
    end
  end

  // Control FSM and shared datapath registers; abort in any busy state drops straight to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      iter_cnt  <= '0;
      iter_tgt  <= '0;
      zero_wait <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      prod      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            iter_tgt <= num_iter;
            iter_cnt <= '0;
            idx      <= '0;
            if (num_iter != 8'd0) begin
              state <= FETCH;
            end else begin
              state     <= FIN;
              zero_wait <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            diff  <= I_VAL - h_data - p_data;
            state <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            prod  <= $signed({{16{diff[63]}}, diff}) * $signed({{64{w_sel[15]}}, w_sel});
            state <= UPD;
          end
        end
        UPD: begin
          if (abort) begin
            state <= IDLE;
          end else if (idx == 4'd8) begin
            iter_cnt <= iter_cnt + 8'd1;
            if (last_iter) begin
              state <= FIN;
            end else begin
              idx   <= '0;
              state <= FETCH;
            end
          end else begin
            idx   <= idx + 4'd1;
            state <= FETCH;
          end
        end
        FIN: begin
          // A zero-iteration run lingers one extra cycle so its done lands at the same offset.
          if (zero_wait) begin
            zero_wait <= 1'b0;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if ((state == IDLE) && w_ld && (w_ld_idx == 4'(i))) begin
          w[i] <= w_ld_data;
        end else if ((state == UPD) && !abort && (idx == 4'(i))) begin
          w[i] <= upd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_ica_wupdate_ctrl.sv
// Scoreboard bench for ica_wupdate_ctrl: stimulus pushes predicted run outcomes,
// a monitor pops them whenever the DUT ends a run (done pulse or busy drop).
`timescale 1ns/1ps
module tb_ica_wupdate_ctrl;

  localparam logic signed [63:0] I_VAL = 64'sd2305843009000000000;

  typedef struct packed {
    logic            is_done;
    logic [31:0]     end_cyc;
    logic [7:0]      iter;
    logic [8:0][15:0] w;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_iter = '0;
  logic        abort = 1'b0;
  logic [3:0]  elem_idx;
  logic [63:0] h_data, p_data;
  logic        w_ld = 1'b0;
  logic [3:0]  w_ld_idx = '0;
  logic [15:0] w_ld_data = '0;
  logic [3:0]  rd_idx = '0;
  logic [15:0] w_rd_data;
  logic        busy, done;
  logic [7:0]  iter_cnt;

  logic [63:0] h_mem [16];
  logic [63:0] p_mem [16];
  logic [15:0] load_w [9];
  logic [15:0] model_w [9];
  rec_t        exp_q [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pushed = 0;
  int          handled = 0;

  assign h_data = h_mem[elem_idx];
  assign p_data = p_mem[elem_idx];

  ica_wupdate_ctrl #(.I_VAL(I_VAL)) dut (
    .clk(clk), .rst(rst), .start(start), .num_iter(num_iter), .abort(abort),
    .elem_idx(elem_idx), .h_data(h_data), .p_data(p_data),
    .w_ld(w_ld), .w_ld_idx(w_ld_idx), .w_ld_data(w_ld_data),
    .w_rd_idx(rd_idx), .w_rd_data(w_rd_data),
    .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: each element evolves independently; run is the first upd element-updates in order.
  function automatic rec_t model(input int n, input int a, input int k);
    rec_t r;
    logic signed [15:0] wv [9];
    logic signed [63:0] d;
    logic signed [79:0] pr;
    logic signed [79:0] sh;
    int upd;
    for (int i = 0; i < 9; i++) wv[i] = load_w[i];
    upd = 9 * n;
    if (a > 0 && (a - 1) / 3 < upd) upd = (a - 1) / 3;
    for (int j = 0; j < upd; j++) begin
      int e;
      e = j % 9;
      d = I_VAL - $signed(h_mem[e]) - $signed(p_mem[e]);
      pr = d * wv[e];
      sh = pr >>> 47;
      wv[e] = wv[e] + $signed(sh[15:0]);
    end
    r.is_done = (a == 0);
    r.end_cyc = (a > 0) ? 32'(k + a) : ((n == 0) ? 32'(k + 2) : 32'(k + 27 * n + 1));
    r.iter = 8'(upd / 9);
    for (int i = 0; i < 9; i++) r.w[i] = wv[i];
    return r;
  endfunction

  task automatic applyStimulus(input int n, input int a, input bit do_load,
                               input bit ld_with_start, input bit noise);
    rec_t r;
    int k;
    int span;
    if (!do_load) for (int i = 0; i < 9; i++) load_w[i] = model_w[i];
    if (do_load) begin
      for (int i = 0; i < 9; i++) begin
        @(posedge clk); #1;
        w_ld = 1'b1; w_ld_idx = 4'(i); w_ld_data = load_w[i];
        if (noise) abort = 1'($urandom_range(0, 1));
        if (i == 8 && ld_with_start) begin start = 1'b1; num_iter = 8'(n); end
      end
    end
    if (!(do_load && ld_with_start)) begin
      @(posedge clk); #1;
      w_ld = 1'b0; start = 1'b1; num_iter = 8'(n);
    end
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0; w_ld = 1'b0; abort = 1'b0;
    r = model(n, a, k);
    exp_q.push_back(r);
    pushed++;
    for (int i = 0; i < 9; i++) model_w[i] = r.w[i];
    if (n > 0) begin
      checkOutput("busy_after_start", 64'(busy), 64'd1);
      checkOutput("elem_idx_start", 64'(elem_idx), 64'd0);
    end else begin
      checkOutput("busy_zero_run", 64'(busy), 64'd0);
    end
    if (a == 1) abort = 1'b1;
    span = (n == 0) ? 0 : ((a > 0) ? a : 27 * n);
    for (int c = 1; c <= span; c++) begin
      @(posedge clk); #1;
      start = 1'b0; w_ld = 1'b0; abort = 1'b0;
      if (a > 0 && c == a - 1) abort = 1'b1;
      if (noise && c + 1 <= span - 1) begin
        start = 1'($urandom_range(0, 1));
        num_iter = 8'($urandom);
        w_ld = 1'($urandom_range(0, 1));
        w_ld_idx = 4'($urandom);
        w_ld_data = 16'($urandom);
      end
    end
    for (int t = 0; t < 300 && handled < pushed; t++) @(posedge clk);
    if (handled < pushed) begin
      checks++; errors++;
      $display("[TB] FAIL end_timeout actual=%0d required=%0d runs_ended", handled, pushed);
      exp_q.delete();
      handled = pushed;
    end
  endtask

  task automatic handleEnd(input bit saw_done, input int ev_cyc);
    rec_t r;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL unexpected_end actual=cycle%0d required=no_event", ev_cyc);
      return;
    end
    r = exp_q.pop_front();
    checkOutput("end_kind_done", 64'(saw_done), 64'(r.is_done));
    checkOutput("end_cycle", 64'(ev_cyc), 64'(r.end_cyc));
    checkOutput("iter_cnt", 64'(iter_cnt), 64'(r.iter));
    checkOutput("busy_at_end", 64'(busy), 64'd0);
    if (saw_done) begin
      @(negedge clk);
      checkOutput("done_width", 64'(done), 64'd0);
    end
    for (int i = 0; i < 9; i++) begin
      rd_idx = 4'(i);
      #1;
      checkOutput($sformatf("w_final[%0d]", i), 64'(w_rd_data), 64'(r.w[i]));
    end
    handled++;
  endtask

  // Monitor: a busy drop not followed by done next cycle is an aborted run.
  initial begin : monitor
    bit busy_prev, pending, fell;
    int fall_cyc;
    busy_prev = 1'b0; pending = 1'b0; fall_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_prev = 1'b0; pending = 1'b0;
      end else begin
        fell = busy_prev && !busy;
        if (done) begin
          pending = 1'b0;
          handleEnd(1'b1, cyc);
        end else if (pending) begin
          pending = 1'b0;
          handleEnd(1'b0, fall_cyc);
        end
        if (fell) begin pending = 1'b1; fall_cyc = cyc; end
        busy_prev = busy;
      end
    end
  end

  task automatic setAll(input logic [15:0] wv, input logic [63:0] hv, input logic [63:0] pv);
    for (int i = 0; i < 9; i++) begin
      load_w[i] = wv; h_mem[i] = hv; p_mem[i] = pv;
    end
  endtask

  initial begin : stimulus
    int n, a, k;
    for (int i = 0; i < 16; i++) begin h_mem[i] = '0; p_mem[i] = '0; end
    for (int i = 0; i < 9; i++) begin load_w[i] = '0; model_w[i] = '0; end
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_iter_cnt", 64'(iter_cnt), 64'd0);
    checkOutput("reset_elem_idx", 64'(elem_idx), 64'd0);
    checkOutput("reset_w0", 64'(w_rd_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed: identity scale, W=1");
    setAll(16'd1, '0, '0);
    applyStimulus(1, 0, 1'b1, 1'b0, 1'b0);
    $display("[TB] directed: wrap, W=2, load with start");
    setAll(16'd2, '0, '0);
    applyStimulus(1, 0, 1'b1, 1'b1, 1'b0);
    $display("[TB] directed: zero diff, three iterations with noise");
    setAll(16'd5, I_VAL, '0);
    applyStimulus(3, 0, 1'b1, 1'b0, 1'b1);
    $display("[TB] directed: zero iterations");
    setAll(16'h1234, 64'd77, 64'd99);
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b0);
    $display("[TB] directed: abort at cycle 10");
    setAll(16'd1, '0, '0);
    applyStimulus(1, 10, 1'b1, 1'b0, 1'b0);

    $display("[TB] directed: reset mid-run");
    setAll(16'd3, '0, '0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      w_ld = 1'b1; w_ld_idx = 4'(i); w_ld_data = load_w[i];
    end
    @(posedge clk); #1;
    w_ld = 1'b0; start = 1'b1; num_iter = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    while (cyc < k + 15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
    checkOutput("midrun_reset_done", 64'(done), 64'd0);
    checkOutput("midrun_reset_iter_cnt", 64'(iter_cnt), 64'd0);
    checkOutput("midrun_reset_elem_idx", 64'(elem_idx), 64'd0);
    for (int i = 0; i < 9; i++) begin
      rd_idx = 4'(i);
      #1;
      checkOutput($sformatf("midrun_reset_w[%0d]", i), 64'(w_rd_data), 64'd0);
    end
    for (int i = 0; i < 9; i++) model_w[i] = '0;
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] start right after reset, no load");
    setAll(16'd0, 64'h0123_4567_89ab_cdef, 64'd5);
    applyStimulus(1, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 14; r++) begin
      n = int'($urandom_range(0, 3));
      a = 0;
      if (n > 0 && $urandom_range(0, 2) == 0) a = int'($urandom_range(1, 27 * n));
      for (int i = 0; i < 9; i++) begin
        load_w[i] = 16'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          h_mem[i] = {$urandom, $urandom};
          p_mem[i] = {$urandom, $urandom};
        end else begin
          h_mem[i] = I_VAL - 64'($urandom_range(0, 1 << 20));
          p_mem[i] = 64'($urandom_range(0, 1 << 12));
        end
      end
      applyStimulus(n, a, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ica_wupdate_ctrl.md
ICA_WUPDATE_CTRL -- requirements
Module: ica_wupdate_ctrl

Interface
REQ-001 SHALL have parameter I_VAL, 64'd2305843009000000000, signed identity-scale constant applied to all nine elements.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to run num_iter update iterations.
REQ-005 SHALL have port num_iter  input  8  iteration count, sampled with accepted start.
REQ-006 SHALL have port abort  input  1  terminate run in progress.
REQ-007 SHALL have port elem_idx  output  4  element index 0..8 (row-major: row*3+col) presented to external h/p source.
REQ-008 SHALL have port h_data  input  64  signed h element for elem_idx, combinational, same cycle.
REQ-009 SHALL have port p_data  input  64  signed p element for elem_idx, combinational, same cycle.
REQ-010 SHALL have ports w_ld / w_ld_idx / w_ld_data  input  1/4/16  write of signed W element while idle.
REQ-011 SHALL have ports w_rd_idx / w_rd_data  input 4 / output 16  combinational readback of W element.
REQ-012 SHALL have port busy  output  1  run in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at normal completion.
REQ-014 SHALL have port iter_cnt  output  8  iterations completed in current/last run.

Function
REQ-015 SHALL hold internal W as nine signed 16-bit registers; one shared subtract-multiply-add datapath, time-multiplexed over elements.
REQ-016 SHALL implement FSM IDLE, FETCH, CALC, UPD, FIN.
REQ-017 IDLE: start=1 with num_iter>0 -> FETCH, elem 0, iter_cnt<=0, busy<=1; start=1 with num_iter=0 -> FIN.
REQ-018 FETCH: drive elem_idx, register diff = I_VAL - h_data - p_data (64-bit signed, two's-complement wrap) -> CALC.
REQ-019 CALC: register prod = diff * W[idx], signed 80-bit full product -> UPD.
REQ-020 UPD: W[idx] <= W[idx] + prod[62:47] (16-bit signed, wrap, no saturation); idx<8 -> idx+1, FETCH; idx=8 -> iter_cnt+1, then FETCH idx 0 if iter_cnt+1<num_iter else FIN.
REQ-021 FIN: done=1 for exactly one cycle, busy=0 in that cycle, -> IDLE.
REQ-022 Timing: start accepted at edge k; busy=1 from k+1; each element 3 cycles; 27 cycles/iteration; done asserted 27*num_iter+1 cycles after k (2 cycles for num_iter=0).
REQ-023 elem_idx SHALL hold last value outside FETCH; h/p sampled only in FETCH.
REQ-024 start while busy SHALL be ignored; num_iter latched, later changes ignored.
REQ-025 w_ld SHALL write only in IDLE; ignored while busy; w_ld and start same cycle in IDLE: load applied, run starts, first FETCH uses loaded value.
REQ-026 abort while busy SHALL return to IDLE next cycle, busy=0, no done, UPD write in abort cycle suppressed, completed element updates retained; abort in IDLE ignored.
REQ-027 w_rd_data SHALL reflect W at all times, including mid-run.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, W all 0, busy=0, done=0, iter_cnt=0, elem_idx=0, internal diff/prod=0, regardless of state.
REQ-029 After rst deassertion, first start accepted on next rising edge.

Verification
REQ-030 Load W all 1, h=p=0, start num_iter=1 -> done 28 cycles after start edge, all W=16384 (0x4000), iter_cnt=1.
REQ-031 Load W all 2, h=p=0, num_iter=1 -> delta 32767, all W=-32767 (0x8001) by wrap.
REQ-032 Load W all 5, h=I_VAL, p=0, num_iter=3 -> W unchanged 5, done after 82 cycles, iter_cnt=3.
REQ-033 num_iter=0 start -> done pulse 2 cycles after start, busy never 1, W unchanged.
REQ-034 W all 1, h=p=0, num_iter=1, abort at cycle 10 after start -> busy low next cycle, no done, W[0..2]=16384, W[3..8]=1.
REQ-035 rst pulse mid-run (cycle 15) -> outputs and W zero asynchronously; start, w_ld during busy ignored elsewhere.
